// File: rtl/wbc2pipeline.sv
// Bridges a Wishbone classic master onto a Wishbone pipelined slave.
// Latency: stb sampled at cycle 0 -> o_mstb at cycle 1; slave ack at cycle N -> o_sack at N+1.
// Backpressure: o_mstb holds with o_m* frozen while i_mstall; one request outstanding at a time.
//
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_scyc/i_sstb/i_swe/...    classic slave port from the master
//   o_sack/o_serr/o_sdata      one-cycle classic response, read data valid with o_sack
//   o_mcyc/o_mstb/o_m*         registered pipelined request toward the slave
//   i_mstall/i_mack/i_merr     pipelined flow control and response, i_mdata read data
module wbc2pipeline #(
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int LGTIMEOUT = 0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_scyc,
    input  logic            i_sstb,
    input  logic            i_swe,
    input  logic [AW-1:0]   i_saddr,
    input  logic [DW-1:0]   i_sdata,
    input  logic [DW/8-1:0] i_ssel,
    output logic            o_sack,
    output logic            o_serr,
    output logic [DW-1:0]   o_sdata,
    output logic            o_mcyc,
    output logic            o_mstb,
    output logic            o_mwe,
    output logic [AW-1:0]   o_maddr,
    output logic [DW-1:0]   o_mdata,
    output logic [DW/8-1:0] o_msel,
    input  logic            i_mstall,
    input  logic            i_mack,
    input  logic [DW-1:0]   i_mdata,
    input  logic            i_merr
);

    localparam int CW = (LGTIMEOUT > 0) ? LGTIMEOUT : 1;
    localparam logic [CW-1:0] TMAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACK
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic            w_timeout;

    // Saturating watchdog count; it fires on the cycle the count reaches
    // its limit, so the error lands 2**LGTIMEOUT-1 cycles after issue.
    assign w_count_nxt = (r_count == TMAX) ? TMAX : r_count + 1'b1;
    assign w_timeout   = (LGTIMEOUT > 0) && (w_count_nxt == TMAX);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            o_sack  <= 1'b0;
            o_serr  <= 1'b0;
            o_sdata <= '0;
            o_mcyc  <= 1'b0;
            o_mstb  <= 1'b0;
            o_mwe   <= 1'b0;
            o_maddr <= '0;
            o_mdata <= '0;
            o_msel  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_sack <= 1'b0;
                    o_serr <= 1'b0;
                    o_mstb <= 1'b0;
                    // Keep CYC up between transfers of one classic cycle.
                    o_mcyc <= i_scyc && (o_mcyc || i_sstb);
                    if (i_scyc && i_sstb) begin
                        o_mwe   <= i_swe;
                        o_maddr <= i_saddr;
                        o_mdata <= i_sdata;
                        o_msel  <= i_ssel;
                        o_mcyc  <= 1'b1;
                        o_mstb  <= 1'b1;
                        r_count <= '0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_count <= w_count_nxt;
                    if (!i_scyc) begin
                        o_mcyc  <= 1'b0;
                        o_mstb  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        o_serr  <= 1'b1;
                        o_mcyc  <= 1'b0;
                        o_mstb  <= 1'b0;
                        r_state <= S_ACK;
                    end else if (!i_mstall) begin
                        o_mstb  <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_count <= w_count_nxt;
                    if (!i_scyc) begin
                        o_mcyc  <= 1'b0;
                        o_mstb  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (i_merr) begin
                        // Error takes precedence over a simultaneous ack.
                        o_serr  <= 1'b1;
                        r_state <= S_ACK;
                    end else if (i_mack) begin
                        o_sack  <= 1'b1;
                        o_sdata <= i_mdata;
                        r_state <= S_ACK;
                    end else if (w_timeout) begin
                        o_serr  <= 1'b1;
                        o_mcyc  <= 1'b0;
                        o_mstb  <= 1'b0;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    // Stb is still high from the finished transfer; do not look at it.
                    o_sack  <= 1'b0;
                    o_serr  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wbc2pipeline.sv
module tb_wbc2pipeline;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          scyc, sstb, swe;
    logic [AW-1:0] saddr;
    logic [DW-1:0] swdat;
    logic [SW-1:0] ssel;
    logic          mstall, mack, merr;
    logic [DW-1:0] mrdat;

    logic          sack, serr, mcyc, mstb, mwe;
    logic [DW-1:0] srdat, mwdat;
    logic [AW-1:0] maddr;
    logic [SW-1:0] msel;

    logic          w3_sack, w3_serr, w3_mcyc, w3_mstb, w3_mwe;
    logic [DW-1:0] w3_srdat, w3_mwdat;
    logic [AW-1:0] w3_maddr;
    logic [SW-1:0] w3_msel;

    always #5 clk = ~clk;

    wbc2pipeline #(.AW(AW), .DW(DW), .LGTIMEOUT(0)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_scyc(scyc), .i_sstb(sstb), .i_swe(swe), .i_saddr(saddr),
        .i_sdata(swdat), .i_ssel(ssel),
        .o_sack(sack), .o_serr(serr), .o_sdata(srdat),
        .o_mcyc(mcyc), .o_mstb(mstb), .o_mwe(mwe), .o_maddr(maddr),
        .o_mdata(mwdat), .o_msel(msel),
        .i_mstall(mstall), .i_mack(mack), .i_mdata(mrdat), .i_merr(merr)
    );

    wbc2pipeline #(.AW(AW), .DW(DW), .LGTIMEOUT(3)) dut_wd (
        .i_clk(clk), .i_reset(rst),
        .i_scyc(scyc), .i_sstb(sstb), .i_swe(swe), .i_saddr(saddr),
        .i_sdata(swdat), .i_ssel(ssel),
        .o_sack(w3_sack), .o_serr(w3_serr), .o_sdata(w3_srdat),
        .o_mcyc(w3_mcyc), .o_mstb(w3_mstb), .o_mwe(w3_mwe), .o_maddr(w3_maddr),
        .o_mdata(w3_mwdat), .o_msel(w3_msel),
        .i_mstall(mstall), .i_mack(mack), .i_mdata(mrdat), .i_merr(merr)
    );

    // One classic transfer: stimulus plus the bench's expectation.
    // ns = stall cycles, nd = idle cycles in WAIT before the slave responds.
    // exp_cyc = cycle (stb sampled at 0) on which o_sack/o_serr is seen.
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] sel;
        logic [DW-1:0] rdata;
        int            ns;
        int            nd;
        logic          ack;
        logic          err;
        int            exp_cyc;
        logic          exp_err;
    } vec_t;

    int            ntests = 0;
    int            nfail  = 0;
    logic [DW-1:0] last_sdata;
    vec_t          tbl[5];
    vec_t          v;

    function automatic vec_t mk(input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [SW-1:0] sel,
                                input logic [DW-1:0] rdata, input int ns, input int nd,
                                input logic ack, input logic err,
                                input int exp_cyc, input logic exp_err);
        vec_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.sel = sel; r.rdata = rdata;
        r.ns = ns; r.nd = nd; r.ack = ack; r.err = err;
        r.exp_cyc = exp_cyc; r.exp_err = exp_err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one transfer and check every cycle until the ACK cycle has passed.
    task automatic run_xfer(input vec_t x, input bit keep);
        int            r_exp, r_drv, rmax;
        logic [DW-1:0] exp_sd;
        logic [63:0]   exp_req;
        r_exp   = x.exp_cyc - 1;
        r_drv   = x.ns + 2 + x.nd;
        rmax    = (r_exp > r_drv) ? r_exp : r_drv;
        exp_sd  = x.exp_err ? last_sdata : x.rdata;
        exp_req = {15'd0, x.we, x.addr, x.wdata, x.sel};
        scyc = 1'b1; sstb = 1'b1; swe = x.we; saddr = x.addr; swdat = x.wdata; ssel = x.sel;
        mstall = 1'b0; mack = 1'b0; merr = 1'b0;
        for (int e = 0; e <= rmax + 1; e++) begin
            tick;
            chk("mstb", mstb, e <= x.ns);
            chk("mcyc", mcyc, 1);
            chk("sack", sack, (e == r_exp) && !x.exp_err);
            chk("serr", serr, (e == r_exp) && x.exp_err);
            chk("mreq", {15'd0, mwe, maddr, mwdat, msel}, exp_req);
            chk("sdata", srdat, (e >= r_exp) ? exp_sd : last_sdata);
            mstall = (e + 1 <= x.ns);
            mack   = 1'b0;
            merr   = 1'b0;
            mrdat  = $urandom;
            if (e + 1 <= x.ns) mack = 1'($urandom_range(0, 1));   // stray ack while stalled
            if (e + 1 == r_drv) begin
                mack  = x.ack;
                merr  = x.err;
                mrdat = x.rdata;
            end
        end
        last_sdata = exp_sd;
        sstb = 1'b0; scyc = keep; mack = 1'b0; merr = 1'b0; mstall = 1'b0;
    endtask

    initial begin
        tbl[0] = mk(1'b0, 12'h123, 32'h0,        4'hF, 32'hDEADBEEF, 0, 0, 1'b1, 1'b0, 3, 1'b0);
        tbl[1] = mk(1'b1, 12'h010, 32'hA5A5A5A5, 4'h3, 32'h11111111, 3, 0, 1'b1, 1'b0, 6, 1'b0);
        tbl[2] = mk(1'b0, 12'h7FF, 32'h0,        4'hF, 32'h22222222, 1, 2, 1'b0, 1'b1, 6, 1'b1);
        tbl[3] = mk(1'b0, 12'h000, 32'h0,        4'h1, 32'h33333333, 0, 1, 1'b1, 1'b1, 4, 1'b1);
        tbl[4] = mk(1'b1, 12'hFFF, 32'h01234567, 4'hF, 32'h44444444, 0, 3, 1'b1, 1'b0, 6, 1'b0);

        rst = 1'b1; scyc = 0; sstb = 0; swe = 0; saddr = '0; swdat = '0; ssel = '0;
        mstall = 0; mack = 0; merr = 0; mrdat = '0;
        last_sdata = '0;
        tick; tick;
        chk("reset_outs", {sack, serr, mcyc, mstb, mwe}, 5'd0);
        chk("reset_addr_sel", {maddr, msel}, 0);
        chk("reset_data", {mwdat, srdat}, 0);
        chk("reset_wd_outs", {w3_sack, w3_serr, w3_mcyc, w3_mstb, w3_mwe, w3_maddr, w3_msel}, 0);
        rst = 1'b0;
        tick;

        // Table-driven transfers, each in its own classic cycle.
        for (int i = 0; i < 5; i++) begin
            run_xfer(tbl[i], 1'b0);
            tick;
            chk("cyc_end_mcyc", mcyc, 0);
        end

        // Back-to-back writes in one classic cycle: CYC never drops in between.
        run_xfer(mk(1'b1, 12'h0A0, 32'hCAFEF00D, 4'hC, 32'h0, 0, 0, 1'b1, 1'b0, 3, 1'b0), 1'b1);
        run_xfer(mk(1'b1, 12'h0A1, 32'hBEEFCAFE, 4'h3, 32'h0, 1, 0, 1'b1, 1'b0, 4, 1'b0), 1'b0);
        tick;
        chk("b2b_mcyc_fall", mcyc, 0);

        // Abort: CYC dropped while waiting for the response.
        scyc = 1; sstb = 1; swe = 0; saddr = 12'h321; mstall = 0;
        tick;
        chk("abort_mstb", mstb, 1);
        tick;
        chk("abort_wait_mcyc", mcyc, 1);
        scyc = 0; sstb = 0;
        tick;
        chk("abort_mcyc", {mcyc, mstb, sack, serr}, 4'b0000);
        mack = 1; merr = 0;
        tick;
        chk("abort_late_ack", {sack, serr, mcyc}, 3'b000);
        mack = 0;
        run_xfer(mk(1'b0, 12'h322, 32'h0, 4'hF, 32'h5A5A0001, 0, 0, 1'b1, 1'b0, 3, 1'b0), 1'b0);
        tick;

        // Reset while the request is stalled.
        scyc = 1; sstb = 1; swe = 1; saddr = 12'h444; swdat = 32'h12345678; mstall = 1;
        tick;
        tick;
        chk("rst_pre_mstb", mstb, 1);
        rst = 1;
        tick;
        chk("rst_mid_outs", {mcyc, mstb, sack, serr}, 4'b0000);
        chk("rst_mid_regs", {maddr, srdat}, 0);
        last_sdata = '0;
        rst = 0; scyc = 0; sstb = 0; mstall = 0;
        tick;
        run_xfer(mk(1'b0, 12'h445, 32'h0, 4'hF, 32'h0BADF00D, 2, 1, 1'b1, 1'b0, 6, 1'b0), 1'b0);
        tick;

        // Randomized transfers against the transaction-level expectation.
        for (int i = 0; i < 40; i++) begin
            int gap;
            bit keep;
            v.we    = 1'($urandom_range(0, 1));
            v.addr  = AW'($urandom);
            v.wdata = $urandom;
            v.sel   = SW'($urandom);
            v.rdata = $urandom;
            v.ns    = $urandom_range(0, 3);
            v.nd    = $urandom_range(0, 3);
            v.ack   = 1'($urandom_range(0, 1));
            v.err   = ($urandom_range(0, 3) == 0);
            if (!v.ack && !v.err) v.ack = 1'b1;
            v.exp_cyc = v.ns + v.nd + 3;
            v.exp_err = v.err;
            keep = 1'($urandom_range(0, 1));
            run_xfer(v, keep);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick;
                chk("gap_mcyc", mcyc, keep);
                chk("gap_resp", {sack, serr, mstb}, 3'b000);
            end
        end
        scyc = 0;
        tick;

        // Watchdog: slave never answers.
        rst = 1;
        tick;
        rst = 0; mstall = 0; mack = 0; merr = 0;
        scyc = 1; sstb = 1; swe = 0; saddr = 12'h055;
        tick;
        chk("wd_mstb", w3_mstb, 1);
        for (int e = 1; e <= 7; e++) begin
            tick;
            chk("wd_serr", w3_serr, e == 7);
            chk("wd_mcyc", w3_mcyc, e < 7);
            chk("wd_sack", w3_sack, 0);
        end
        scyc = 0; sstb = 0; mack = 1;
        for (int e = 0; e < 4; e++) begin
            tick;
            chk("wd_late_ack", {w3_sack, w3_serr, w3_mcyc}, 3'b000);
        end
        mack = 0;
        rst = 1;
        tick;
        rst = 0;
        tick;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
